nibble_serial_adder_ctrl: RTL
=============================

Name: nibble_serial_adder_ctrl

Overview:
- Sequencing controller that adds or subtracts two WIDTH-bit operands by reusing a single 4-bit ripple adder slice, one nibble per clock, least significant nibble first.
- Sits between a requester (valid/ready input handshake) and a consumer (valid/ready output handshake).
- Owns the operand shift registers, the inter-nibble carry register, the nibble counter and the control FSM.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4.
- NIBBLES, WIDTH/4, derived nibble count; not to be overridden.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  requester presents a, b, cin, sub.
- in_ready  output  1  controller can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, immediate): state=IDLE; in_ready=1; out_valid=0; busy=0; sum=0; cout=0; ovf=0; counter, carry and shift registers all cleared.
- Reset asserted mid-operation aborts the operation with no partial output.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, latch the operands: opA=a; opB = sub ? ~b : b; carry = sub ? 1 : cin.
  - Capture sa=a[WIDTH-1] and sb=opB[WIDTH-1]; clear nib_cnt; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the slice computes opA[3:0] + opB[3:0] + carry.
  - The 4-bit result is shifted into the top of the result register, with the result register shifting right by 4.
  - opA and opB shift right by 4; carry takes the slice carry-out; nib_cnt increments.
  - When nib_cnt == NIBBLES-1, go to DONE at that edge. cout = final carry. ovf = (sa == sb) && (result MSB != sa).
- DONE:
  - out_valid=1; sum, cout and ovf are held stable while out_valid=1 && out_ready=0.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - sum, cout and ovf retain their values in IDLE until the next completion.
- Latency: accept at edge k; out_valid=1 after edge k+NIBBLES. WIDTH=4 gives a single RUN cycle.
- Throughput: at most one operation per NIBBLES+2 cycles. in_ready is low in DONE, so a new operation cannot be accepted in the same cycle the result is consumed.
- Inputs a, b, cin and sub are don't-care outside the accept cycle. Changes during RUN or DONE have no effect.
- in_valid asserted during RUN or DONE is not accepted; the requester must hold it until in_ready.
- nib_cnt width is clog2(NIBBLES), minimum 1 bit. It never wraps within an operation.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a NIBBLE_W=4 constant.
- One sub-module, nibble_adder: purely combinational 4-bit a+b+cin producing a 4-bit sum and cout.
- The FSM, counter and shift registers stay in nibble_serial_adder_ctrl.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x0FCD, cin=0, sub=0, out_ready=1 -> sum=0x2201, cout=0, ovf=0; out_valid rises exactly 4 cycles after accept.
2. a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0. Repeat with a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
3. sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0 (borrow), ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
4. a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands applied. Required: sum/cout/ovf stable, in_ready=0, no new accept. Release out_ready -> IDLE, then the new operation is accepted one cycle later.
6. Assert rst during RUN after 2 nibbles. Required: out_valid=0, busy=0, sum=0 immediately, without waiting for a clock edge. After release, in_ready=1 and a following 0x1234+0x0FCD returns 0x2201.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl_pkg
// Shared definitions for the nibble-serial adder controller:
//   - state_t   : FSM state encoding (IDLE / RUN / DONE)
//   - NIBBLE_W  : width of the reused adder slice
//   - cnt_width : width of a counter that must reach (n-1), at least 1 bit
// -----------------------------------------------------------------------------
package nibble_serial_adder_ctrl_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_nibble_adder.sv
// -----------------------------------------------------------------------------
// nibble_adder
// Purely combinational 4-bit ripple slice: {o_cout, o_sum} = i_a + i_b + i_cin.
// Ports:
//   i_a, i_b  : 4-bit addends
//   i_cin     : carry in
//   o_sum     : 4-bit sum
//   o_cout    : carry out of bit 3
// -----------------------------------------------------------------------------
module nibble_adder
   import nibble_serial_adder_ctrl_pkg::*;
(
   input  logic [NIBBLE_W-1:0] i_a,
   input  logic [NIBBLE_W-1:0] i_b,
   input  logic                i_cin,
   output logic [NIBBLE_W-1:0] o_sum,
   output logic                o_cout
);

   logic [NIBBLE_W:0] w_total;

   // Widen by one bit so the carry out falls into the top bit.
   assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{NIBBLE_W{1'b0}}, i_cin};
   assign o_sum   = w_total[NIBBLE_W-1:0];
   assign o_cout  = w_total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Adds or subtracts two WIDTH-bit operands one nibble per clock (LSN first)
// through a single shared 4-bit adder slice.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   in_valid   : requester presents a, b, cin, sub
//   in_ready   : controller can accept an operation (IDLE only)
//   a, b       : WIDTH-bit operands
//   cin        : carry in (add only)
//   sub        : 0 -> a+b+cin, 1 -> a-b
//   out_valid  : result available (DONE)
//   out_ready  : consumer accepts the result
//   sum        : WIDTH-bit result
//   cout       : carry out of the MSB (for sub: 1 = no borrow)
//   ovf        : two's-complement signed overflow
//   busy       : high in RUN or DONE
// WIDTH must be a multiple of 4 and at least 4; NIBBLES is derived.
// -----------------------------------------------------------------------------
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int NIBBLES = WIDTH / 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int CNT_W = cnt_width(NIBBLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_op_a;
   logic [WIDTH-1:0]   r_op_b;
   logic [WIDTH-1:0]   r_res;
   logic               r_carry;
   logic [CNT_W-1:0]   r_nib_cnt;
   logic               r_sa;
   logic               r_sb;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               r_ovf;

   logic [NIBBLE_W-1:0]       w_nib_sum;
   logic                      w_nib_cout;
   logic [WIDTH+NIBBLE_W-1:0] w_res_cat;
   logic [WIDTH-1:0]          w_res_next;
   logic [WIDTH-1:0]          w_b_eff;
   logic                      w_accept;
   logic                      w_last;

   nibble_adder u_slice (
      .i_a    (r_op_a[NIBBLE_W-1:0]),
      .i_b    (r_op_b[NIBBLE_W-1:0]),
      .i_cin  (r_carry),
      .o_sum  (w_nib_sum),
      .o_cout (w_nib_cout)
   );

   // New nibble enters at the top while the result shifts right; taking the
   // upper WIDTH bits of the concatenation also covers WIDTH == 4.
   assign w_res_cat  = {w_nib_sum, r_res};
   assign w_res_next = w_res_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
   assign w_b_eff    = sub ? ~b : b;
   assign w_accept   = in_valid && r_in_ready;
   assign w_last     = (r_nib_cnt == CNT_LAST);

   // Control FSM, operand/result shift registers, counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_res       <= '0;
         r_carry     <= 1'b0;
         r_nib_cnt   <= '0;
         r_sa        <= 1'b0;
         r_sb        <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op_a      <= a;
                  r_op_b      <= w_b_eff;
                  r_carry     <= sub ? 1'b1 : cin;
                  r_sa        <= a[WIDTH-1];
                  r_sb        <= w_b_eff[WIDTH-1];
                  r_nib_cnt   <= '0;
                  r_res       <= '0;
                  r_in_ready  <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_RUN;
               end else begin
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end

            ST_RUN: begin
               r_op_a    <= r_op_a >> NIBBLE_W;
               r_op_b    <= r_op_b >> NIBBLE_W;
               r_carry   <= w_nib_cout;
               r_res     <= w_res_next;
               if (w_last) begin
                  // Final nibble: publish the result; counter stays put so it
                  // never wraps inside an operation.
                  r_sum       <= w_res_next;
                  r_cout      <= w_nib_cout;
                  r_ovf       <= (r_sa == r_sb) && (w_res_next[WIDTH-1] != r_sa);
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_nib_cnt   <= r_nib_cnt + CNT_W'(1);
                  r_state     <= ST_RUN;
               end
            end

            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end else begin
                  r_state     <= ST_DONE;
               end
            end

            default: begin
               // Unreachable encoding: recover to a clean idle state.
               r_state     <= ST_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule
